// File: rtl/interrupt_sequencer.sv
// Interrupt-entry sequencer: drains the pipeline, pushes the return PC and flags,
// fetches the handler vector, loads it into the PC, then tracks handler residency until RTI.
module interrupt_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_signal,
  input  logic        ctrl_flow_busy,
  input  logic [31:0] pc_current,
  input  logic [2:0]  flags,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        rti_retired,
  output logic        stall_fetch,
  output logic        insert_bubble,
  output logic        mem_req,
  output logic        mem_op,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        in_isr,
  output logic        irq_pending
);

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_PC_HI,
    PUSH_PC_LO,
    PUSH_FLAGS,
    RD_VEC_HI,
    RD_VEC_LO,
    LOAD_PC,
    IN_ISR
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_next;
  logic        irq_d;
  logic        pending;
  logic [31:0] saved_pc;
  logic [2:0]  saved_flags;
  logic [31:0] vec;
  logic [3:0]  count;
  logic        rise;
  logic        start;

  assign rise  = interrupt_signal & ~irq_d;
  assign start = (state == IDLE) & pending & ~ctrl_flow_busy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = DRAIN;
      DRAIN:      if (count == 4'd0) state_next = PUSH_PC_HI;
      PUSH_PC_HI: if (mem_ack) state_next = PUSH_PC_LO;
      PUSH_PC_LO: if (mem_ack) state_next = PUSH_FLAGS;
      PUSH_FLAGS: if (mem_ack) state_next = RD_VEC_HI;
      RD_VEC_HI:  if (mem_ack) state_next = RD_VEC_LO;
      RD_VEC_LO:  if (mem_ack) state_next = LOAD_PC;
      LOAD_PC:    state_next = IN_ISR;
      IN_ISR:     if (rti_retired) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // A fresh rise always wins over the clear that happens on DRAIN entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq_d       <= 1'b0;
      pending     <= 1'b0;
      saved_pc    <= 32'd0;
      saved_flags <= 3'd0;
      vec         <= 32'd0;
      count       <= 4'd0;
    end else begin
      state   <= state_next;
      irq_d   <= interrupt_signal;
      pending <= rise | (pending & ~start);
      if (start) begin
        saved_pc    <= pc_current;
        saved_flags <= flags;
        count       <= DRAIN_LOAD;
      end else if (state == DRAIN && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (state == RD_VEC_HI && mem_ack) vec[31:16] <= mem_rdata;
      if (state == RD_VEC_LO && mem_ack) vec[15:0]  <= mem_rdata;
    end
  end

  always_comb begin
    stall_fetch   = 1'b0;
    insert_bubble = 1'b0;
    mem_req       = 1'b0;
    mem_op        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 16'd0;
    pc_load       = 1'b0;
    pc_load_value = 32'd0;
    in_isr        = 1'b0;
    irq_pending   = pending;
    case (state)
      DRAIN: begin
        stall_fetch   = 1'b1;
        insert_bubble = 1'b1;
      end
      PUSH_PC_HI: begin
        stall_fetch   = 1'b1;
        insert_bubble = 1'b1;
        mem_req       = 1'b1;
        mem_wdata     = saved_pc[31:16];
      end
      PUSH_PC_LO: begin
        stall_fetch   = 1'b1;
        insert_bubble = 1'b1;
        mem_req       = 1'b1;
        mem_wdata     = saved_pc[15:0];
      end
      PUSH_FLAGS: begin
        stall_fetch   = 1'b1;
        insert_bubble = 1'b1;
        mem_req       = 1'b1;
        mem_wdata     = {13'd0, saved_flags};
      end
      RD_VEC_HI: begin
        stall_fetch   = 1'b1;
        insert_bubble = 1'b1;
        mem_req       = 1'b1;
        mem_op        = 1'b1;
        mem_addr      = VECTOR_ADDR;
      end
      RD_VEC_LO: begin
        stall_fetch   = 1'b1;
        insert_bubble = 1'b1;
        mem_req       = 1'b1;
        mem_op        = 1'b1;
        mem_addr      = VECTOR_ADDR + 32'd1;
      end
      // Fetch is released here so the handler address actually reaches the PC.
      LOAD_PC: begin
        insert_bubble = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = vec;
      end
      IN_ISR: in_isr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Single-clock controller that turns the external `interrupt_signal` into the ordered hardware interrupt-entry sequence of the 5-stage pipeline. It freezes fetch and drains the in-flight instructions. It then uses the memory stage's push/read port to save the return PC (two 16-bit words) and the 3-bit flags, fetches a 32-bit handler vector, and loads it into the PC. It tracks handler residency until `RTI` retires and holds further requests pending until then.

## Interface
Parameters:
- `DRAIN_CYCLES`, 3, cycles fetch is frozen and bubbles are injected before the first push; legal range 1..15.
- `VECTOR_ADDR`, 32'h0000_0000, data-memory word address of the vector high word; the low word is at `VECTOR_ADDR+1`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `interrupt_signal`  in  1  external request; rising-edge detected.
- `ctrl_flow_busy`  in  1  a jump/call/ret is resolving in execute/memory; entry must not start while high.
- `pc_current`  in  32  PC of the oldest not-yet-issued instruction (the return address).
- `flags`  in  3  flag register from execute.
- `mem_ack`  in  1  memory stage accepted the current request this cycle.
- `mem_rdata`  in  16  read data; valid in the cycle `mem_ack=1` during a read.
- `rti_retired`  in  1  one-cycle pulse when `RTI` completes write-back.
- `stall_fetch`  out  1  freeze PC and the fetch/decode register.
- `insert_bubble`  out  1  force a NOP into decode (clears control bits).
- `mem_req`  out  1  memory request valid.
- `mem_op`  out  1  0 = push, 1 = read.
- `mem_addr`  out  32  read address; 0 during pushes, because the memory stage owns SP.
- `mem_wdata`  out  16  push data.
- `pc_load`  out  1  overwrite PC with `pc_load_value` this cycle.
- `pc_load_value`  out  32  handler address.
- `in_isr`  out  1  handler executing.
- `irq_pending`  out  1  request latched, not yet serviced.

## Operation
- Edge detect: `irq_d` is registered `interrupt_signal`. A rise (`interrupt_signal & ~irq_d`) sets `pending`. `pending` clears on the edge that enters `DRAIN`. A rise in the same cycle as that edge keeps `pending` set, so a new edge always wins.
- States: `IDLE`, `DRAIN`, `PUSH_PC_HI`, `PUSH_PC_LO`, `PUSH_FLAGS`, `RD_VEC_HI`, `RD_VEC_LO`, `LOAD_PC`, `IN_ISR`.
- Transitions:
  - `IDLE` → `DRAIN` when `pending & ~ctrl_flow_busy`.
  - On that same edge, capture `saved_pc <= pc_current` and `saved_flags <= flags`, and load the 4-bit counter with `DRAIN_CYCLES-1`.
  - `DRAIN` decrements the counter each cycle and → `PUSH_PC_HI` when it reaches 0.
  - `PUSH_PC_HI` → `PUSH_PC_LO` → `PUSH_FLAGS` → `RD_VEC_HI` → `RD_VEC_LO` → `LOAD_PC`. Each of these advances only on an edge where `mem_ack=1`; without ack the state holds and the request stays stable.
  - `RD_VEC_HI` captures `vec[31:16] <= mem_rdata` on ack; `RD_VEC_LO` captures `vec[15:0]`.
  - `LOAD_PC` → `IN_ISR` unconditionally after 1 cycle.
  - `IN_ISR` → `IDLE` on `rti_retired`.
- Outputs are a Moore decode of the state register plus the data registers:
  - `stall_fetch=1` in `DRAIN` through `RD_VEC_LO`.
  - `insert_bubble=1` in `DRAIN` through `LOAD_PC`.
  - `mem_req=1` in the five memory states.
  - `mem_op=1` only in the `RD_VEC_*` states.
  - `mem_wdata`: `saved_pc[31:16]` in `PUSH_PC_HI`, `saved_pc[15:0]` in `PUSH_PC_LO`, `{13'b0,saved_flags}` in `PUSH_FLAGS`, 0 elsewhere.
  - `mem_addr`: `VECTOR_ADDR` in `RD_VEC_HI`, `VECTOR_ADDR+1` (mod 2^32) in `RD_VEC_LO`.
  - `pc_load=1` and `pc_load_value=vec` only in `LOAD_PC`; `stall_fetch=0` there so the load takes effect.
  - `in_isr=1` in `IN_ISR`.
  - `irq_pending=pending`.
- Push order is fixed at PC high, PC low, flags; `RTI` pops in reverse, which is outside this block.
- Nesting: requests arriving in any non-`IDLE` state only set `pending`. They are serviced after return to `IDLE`. Only one request is remembered; multiple rises collapse into one.
- `rti_retired` outside `IN_ISR` is ignored.
- Reset: all registers cleared, state=`IDLE`, every output 0, `pending=0`, `irq_d=0`. Reset mid-sequence aborts immediately with no further `mem_req`.

## Timing
- Rise sampled at edge E0 sets `pending` after E0. With `ctrl_flow_busy=0` and `DRAIN_CYCLES=3`, `DRAIN` is entered at E1. With every `mem_ack` same-cycle, `PUSH_PC_HI` is at E4, `LOAD_PC` at E9 and `IN_ISR` at E10.
- Total entry latency = 1 + `DRAIN_CYCLES` + 5 + (sum of ack wait cycles) cycles from the sampling edge to `pc_load`.
- Each memory state lasts 1 + (ack wait cycles). `mem_addr`, `mem_wdata` and `mem_op` must not change while `mem_req=1` and `mem_ack=0`.
- `ctrl_flow_busy` is sampled only in `IDLE`; asserting it after `DRAIN` entry has no effect.
- `rti_retired` and a new rise in the same cycle: → `IDLE` with `pending=1`, then `DRAIN` on the next edge if not busy. Back-to-back interrupts therefore have 1 `IDLE` cycle.

## Test plan
- Basic entry: `pc_current`=0x0000_1234, `flags`=3'b101, vector words 0x0000/0x0200, ack always 1, rise at E0 → pushes 0x0000, 0x1234, 0x0005 in that order; `pc_load=1` with 0x0000_0200 in the cycle after E9; `in_isr=1` from E10.
- Ack stall: hold `mem_ack=0` for 3 cycles in `PUSH_PC_LO` → `mem_req`/`mem_wdata`=0x1234 stable for 4 cycles; `pc_load` delayed by exactly 3 cycles.
- Busy gating: `ctrl_flow_busy=1` for 4 cycles after the rise → `stall_fetch` first asserts on the edge after busy drops; `saved_pc` equals `pc_current` at that edge.
- Nested request: rise during `IN_ISR` → `irq_pending=1`, no `mem_req` until `rti_retired`; a second full sequence then follows; a rise on the same cycle as `rti_retired` gives exactly 1 `IDLE` cycle.
- Reset mid-sequence: assert `rst` in `RD_VEC_HI` → next cycle all outputs 0, state `IDLE`, a prior pending request discarded.
- Level hold: `interrupt_signal` held high 20 cycles → exactly one entry sequence, with `irq_pending=0` after `DRAIN` entry.
